muldiv_ctrl: RTL and testbench

//  Execute-stage scheduler for the shared iterative multiplier (mult) and divider (divid).

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_fixup.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the M-extension execute-stage scheduler.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OpMul, OpMulw, OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw
  } muldiv_op_t;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return !(op inside {OpMul, OpMulw});
  endfunction

  function automatic logic is_signed(muldiv_op_t op);
    return op inside {OpDiv, OpRem, OpDivw, OpRemw};
  endfunction

  function automatic logic is_word(muldiv_op_t op);
    return op inside {OpMulw, OpDivw, OpDivuw, OpRemw, OpRemuw};
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return op inside {OpRem, OpRemu, OpRemw, OpRemuw};
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational operand preparation (magnitude/width) and result sign/width fixup.
// Shortcut results for divide-by-zero and signed overflow are formed here too.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  muldiv_op_t        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [2*XLEN-1:0] raw_div,
  input  logic [XLEN-1:0]   raw_mul,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              div_zero,
  output logic              overflow,
  output logic [XLEN-1:0]   short_res,
  output logic [XLEN-1:0]   div_res,
  output logic [XLEN-1:0]   mul_res
);

  function automatic logic [XLEN-1:0] sext32(logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  logic            word, sgn, rem, neg_a, neg_b;
  logic [XLEN-1:0] a_ext, b_ext, min_x, quo, rmd, div_pre;

  always_comb begin
    word  = is_word(op);
    sgn   = is_signed(op);
    rem   = is_rem(op);
    a_ext = word ? (sgn ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]}) : a;
    b_ext = word ? (sgn ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]}) : b;
    neg_a = sgn & a_ext[XLEN-1];
    neg_b = sgn & b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    min_x = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = (b_ext == '0);
    overflow = sgn && (a_ext == min_x) && (b_ext == '1);

    if (div_zero) begin
      short_res = rem ? (word ? sext32(a[31:0]) : a) : '1;
    end else begin
      short_res = rem ? '0 : min_x;
    end

    // Divider works on magnitudes; quotient sign is sign(a)^sign(b), remainder follows a.
    quo     = (neg_a ^ neg_b) ? -raw_div[XLEN-1:0] : raw_div[XLEN-1:0];
    rmd     = neg_a ? -raw_div[2*XLEN-1:XLEN] : raw_div[2*XLEN-1:XLEN];
    div_pre = rem ? rmd : quo;
    div_res = word ? sext32(div_pre[31:0]) : div_pre;
    mul_res = word ? sext32(raw_mul[31:0]) : raw_mul;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Scheduler for the shared iterative multiplier/divider: handshake, FSM, operand and
// result registers, plus a one-entry cache of the last divide for DIV/REM pairs.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter bit          DIV_CACHE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  muldiv_op_t        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              busy,
  output logic              mul_valid,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [XLEN-1:0]   mul_c,
  output logic              div_valid,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic              div_done,
  input  logic [2*XLEN-1:0] div_c
);

  muldiv_state_t     state_q;
  muldiv_op_t        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic              cache_valid_q, cache_sgn_q, cache_word_q;
  logic [XLEN-1:0]   cache_a_q, cache_b_q;
  logic [2*XLEN-1:0] cache_c_q;

  muldiv_op_t        fx_op;
  logic [XLEN-1:0]   fx_a, fx_b, mag_a, mag_b, short_res, div_res, mul_res;
  logic [2*XLEN-1:0] fx_raw;
  logic              div_zero, overflow, accept, cache_hit;

  assign req_ready = reset & ~flush & (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign accept    = req_valid & req_ready;
  assign cache_hit = DIV_CACHE && cache_valid_q && (cache_a_q == req_a) && (cache_b_q == req_b)
                     && (cache_sgn_q == is_signed(req_op)) && (cache_word_q == is_word(req_op));

  // In IDLE the fixup sees the incoming request and cached quotient; otherwise the held op.
  always_comb begin
    fx_op  = (state_q == StIdle) ? req_op : op_q;
    fx_a   = (state_q == StIdle) ? req_a : a_q;
    fx_b   = (state_q == StIdle) ? req_b : b_q;
    fx_raw = (state_q == StIdle) ? cache_c_q : div_c;
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .op        (fx_op),
    .a         (fx_a),
    .b         (fx_b),
    .raw_div   (fx_raw),
    .raw_mul   (mul_c),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .short_res (short_res),
    .div_res   (div_res),
    .mul_res   (mul_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_q          <= OpMul;
      a_q           <= '0;
      b_q           <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mul_valid     <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      div_valid     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      cache_valid_q <= 1'b0;
      cache_sgn_q   <= 1'b0;
      cache_word_q  <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_c_q     <= '0;
    end else if (flush) begin
      state_q    <= StIdle;
      mul_valid  <= 1'b0;
      div_valid  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            if (!is_div(req_op)) begin
              state_q   <= StMul;
              mul_valid <= 1'b1;
              mul_a     <= req_a;
              mul_b     <= req_b;
            end else if (div_zero || overflow) begin
              state_q    <= StDone;
              resp_valid <= 1'b1;
              resp_data  <= short_res;
            end else if (cache_hit) begin
              state_q    <= StDone;
              resp_valid <= 1'b1;
              resp_data  <= div_res;
            end else begin
              state_q   <= StDiv;
              div_valid <= 1'b1;
              div_a     <= mag_a;
              div_b     <= mag_b;
            end
          end
        end
        StMul: begin
          if (mul_done) begin
            state_q    <= StDone;
            mul_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= mul_res;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q       <= StDone;
            div_valid     <= 1'b0;
            resp_valid    <= 1'b1;
            resp_data     <= div_res;
            cache_valid_q <= 1'b1;
            cache_a_q     <= a_q;
            cache_b_q     <= b_q;
            cache_sgn_q   <= is_signed(op_q);
            cache_word_q  <= is_word(op_q);
            cache_c_q     <= div_c;
          end
        end
        StDone: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a hand-driven multiplier/divider model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic         clk = 1'b0, reset = 1'b0, flush = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic         mul_done = 1'b0, div_done = 1'b0;
  muldiv_op_t   req_op = OpMul;
  logic [63:0]  req_a = '0, req_b = '0, mul_c = '0;
  logic [127:0] div_c = '0;
  logic         req_ready, resp_valid, busy, mul_valid, div_valid;
  logic [63:0]  resp_data, mul_a, mul_b, div_a, div_b;
  int           tests = 0, fails = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(64), .DIV_CACHE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_c      (mul_c),
    .div_valid  (div_valid),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_c      (div_c)
  );

  // Offer one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic issue(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic take();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({req_ready, resp_valid, busy, mul_valid, div_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 00000",
               {req_ready, resp_valid, busy, mul_valid, div_valid});
    end
    tests++;
    if (resp_data !== 64'h0) begin fails++; $display("FAIL reset_data got %h want 0", resp_data); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_div_cache();
    logic held = 1'b1;
    issue(OpDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    tests++;
    if ({div_valid, busy, resp_valid} !== 3'b110) begin
      fails++; $display("FAIL div_start got %b want 110", {div_valid, busy, resp_valid});
    end
    tests++;
    if ({div_a, div_b} !== {64'd7, 64'd2}) begin
      fails++; $display("FAIL div_opnd got %h/%h want 7/2", div_a, div_b);
    end
    for (int i = 0; i < 9; i++) begin @(negedge clk); held &= div_valid; end
    div_done = 1'b1; div_c = {64'd1, 64'd3};
    @(negedge clk);
    div_done = 1'b0; div_c = '0;
    tests++;
    if (held !== 1'b1) begin fails++; $display("FAIL div_hold got %b want 1", held); end
    tests++;
    if ({resp_valid, div_valid} !== 2'b10) begin
      fails++; $display("FAIL div_resp got %b want 10", {resp_valid, div_valid});
    end
    tests++;
    if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fails++; $display("FAIL div_data got %h want fffffffffffffffd", resp_data);
    end
    take();
    issue(OpRem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    tests++;
    if ({resp_valid, div_valid} !== 2'b10) begin
      fails++; $display("FAIL rem_hit got %b want 10", {resp_valid, div_valid});
    end
    tests++;
    if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL rem_hit_data got %h want ffffffffffffffff", resp_data);
    end
    take();
  endtask

  task automatic test_div_zero();
    issue(OpDivu, 64'd5, 64'd0);
    tests++;
    if ({resp_valid, div_valid} !== 2'b10) begin
      fails++; $display("FAIL dz_resp got %b want 10", {resp_valid, div_valid});
    end
    tests++;
    if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL dz_quo got %h want ffffffffffffffff", resp_data);
    end
    take();
    issue(OpRemu, 64'd5, 64'd0);
    tests++;
    if (resp_data !== 64'd5) begin fails++; $display("FAIL dz_rem got %h want 5", resp_data); end
    take();
  endtask

  task automatic test_overflow();
    issue(OpDiv, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests++;
    if ({resp_valid, div_valid, resp_data} !== {2'b10, 64'h8000_0000_0000_0000}) begin
      fails++; $display("FAIL ovf_div got %b %h want 10 8000000000000000",
                        {resp_valid, div_valid}, resp_data);
    end
    take();
    issue(OpRemw, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tests++;
    if ({resp_valid, div_valid, resp_data} !== {2'b10, 64'h0}) begin
      fails++; $display("FAIL ovf_remw got %b %h want 10 0", {resp_valid, div_valid}, resp_data);
    end
    take();
  endtask

  task automatic test_mulw_hold();
    logic stable = 1'b1;
    issue(OpMulw, 64'h7FFF_FFFF, 64'd2);
    tests++;
    if ({mul_valid, mul_a, mul_b} !== {1'b1, 64'h7FFF_FFFF, 64'd2}) begin
      fails++; $display("FAIL mul_start got %b %h %h want 1 7fffffff 2", mul_valid, mul_a, mul_b);
    end
    repeat (2) @(negedge clk);
    mul_done = 1'b1; mul_c = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    mul_done = 1'b0; mul_c = '0;
    tests++;
    if ({resp_valid, mul_valid, resp_data} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      fails++; $display("FAIL mulw_data got %b %h want 10 fffffffffffffffe",
                        {resp_valid, mul_valid}, resp_data);
    end
    req_valid = 1'b1; req_op = OpDiv; req_a = 64'd9; req_b = 64'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 64'hFFFF_FFFF_FFFF_FFFE || req_ready || div_valid)
        stable = 1'b0;
    end
    req_valid = 1'b0;
    tests++;
    if (stable !== 1'b1) begin fails++; $display("FAIL hold_stable got %b want 1", stable); end
    take();
    tests++;
    if ({busy, div_valid, resp_valid} !== 3'b000) begin
      fails++; $display("FAIL hold_release got %b want 000", {busy, div_valid, resp_valid});
    end
  endtask

  task automatic test_flush();
    issue(OpDiv, 64'd100, 64'd7);
    @(negedge clk);
    flush = 1'b1; div_done = 1'b1; div_c = {64'd2, 64'd14};
    @(negedge clk);
    flush = 1'b0; div_done = 1'b0; div_c = '0;
    tests++;
    if ({div_valid, busy, resp_valid} !== 3'b000) begin
      fails++; $display("FAIL flush_kill got %b want 000", {div_valid, busy, resp_valid});
    end
    flush = 1'b1; req_valid = 1'b1; req_op = OpDiv; req_a = 64'd100; req_b = 64'd7;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b want 0", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_noaccept got %b want 0", busy); end
    mul_done = 1'b1; div_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0; div_done = 1'b0;
    tests++;
    if ({busy, resp_valid} !== 2'b00) begin
      fails++; $display("FAIL stray_done got %b want 00", {busy, resp_valid});
    end
    issue(OpDiv, 64'd100, 64'd7);
    tests++;
    if ({div_valid, resp_valid} !== 2'b10) begin
      fails++; $display("FAIL flush_nohit got %b want 10", {div_valid, resp_valid});
    end
    div_done = 1'b1; div_c = {64'd2, 64'd14};
    @(negedge clk);
    div_done = 1'b0; div_c = '0;
    tests++;
    if ({resp_valid, resp_data} !== {1'b1, 64'd14}) begin
      fails++; $display("FAIL flush_rerun got %b %h want 1 e", resp_valid, resp_data);
    end
    take();
  endtask

  task automatic test_reset_mid();
    issue(OpMul, 64'd3, 64'd4);
    tests++;
    if (mul_valid !== 1'b1) begin fails++; $display("FAIL rmid_mul got %b want 1", mul_valid); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({mul_valid, busy, resp_valid, req_ready, mul_a} !== {4'b0000, 64'h0}) begin
      fails++; $display("FAIL rmid_async got %b %h want 0000 0",
                        {mul_valid, busy, resp_valid, req_ready}, mul_a);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({req_ready, busy} !== 2'b10) begin
      fails++; $display("FAIL rmid_idle got %b want 10", {req_ready, busy});
    end
    @(negedge clk);
    issue(OpDiv, 64'd100, 64'd7);
    tests++;
    if ({div_valid, resp_valid} !== 2'b10) begin
      fails++; $display("FAIL rmid_cache got %b want 10", {div_valid, resp_valid});
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div_cache();
    test_div_zero();
    test_overflow();
    test_mulw_hold();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
